// File: rtl/barreira_detector.sv
// Modulated light-barrier front end: drives the IR emitter, samples the photoreceiver in the ON and OFF phases, filters per-period verdicts into objeto_perto.
// Latency: receptor is synchronised in 2 cycles; verdicts appear the cycle after the last count of each period; objeto_perto needs N_CONFIRM/N_RELEASE periods.
// Backpressure: none; free-running, one evaluation per 2*HALF_PERIOD cycles.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   receptor      asynchronous photoreceiver output, 1 = light received
//   emissor       registered IR emitter drive, 1 = LED on
//   objeto_perto  filtered "object in barrier" level
//   interferencia ambient light seen in the OFF phase of the last period
//   periodo_fim   one-cycle pulse per period evaluation
module barreira_detector #(
  parameter int HALF_PERIOD = 2500,
  parameter int SETTLE      = 500,
  parameter int N_CONFIRM   = 4,
  parameter int N_RELEASE   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic receptor,
  output logic emissor,
  output logic objeto_perto,
  output logic interferencia,
  output logic periodo_fim
);

  localparam int PERIOD = 2 * HALF_PERIOD;
  localparam int CW     = $clog2(PERIOD);
  localparam int NMAX   = (N_CONFIRM > N_RELEASE) ? N_CONFIRM : N_RELEASE;
  localparam int FW     = $clog2(NMAX + 1);

  localparam logic [CW-1:0] CNT_LAST    = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_HALF    = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] CNT_SMP_ON  = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_SMP_OFF = CW'(HALF_PERIOD + SETTLE);
  localparam logic [FW-1:0] FC_CONFIRM  = FW'(N_CONFIRM - 1);
  localparam logic [FW-1:0] FC_RELEASE  = FW'(N_RELEASE - 1);

  typedef enum logic {
    LIVRE     = 1'b0,
    BLOQUEADO = 1'b1
  } estado_t;

  logic          rx_s1, rx_s2;
  logic          rodando;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          amostra_on, amostra_off;
  logic          avaliar;
  logic          feixe;
  estado_t       estado, estado_n;
  logic [FW-1:0] fcnt, fcnt_n;

  assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
  // rodando holds off counting for the first edge after reset so that
  // edge loads count 0 and raises the emitter.
  assign avaliar = rodando && (cnt == CNT_LAST);
  // Light in the OFF phase (ambient or interference) fails the period.
  assign feixe   = amostra_on & ~amostra_off;

  // Synchroniser, phase counter, emitter and samplers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1       <= 1'b0;
      rx_s2       <= 1'b0;
      rodando     <= 1'b0;
      cnt         <= '0;
      emissor     <= 1'b0;
      amostra_on  <= 1'b0;
      amostra_off <= 1'b0;
    end else begin
      rx_s1 <= receptor;
      rx_s2 <= rx_s1;
      if (!rodando) begin
        rodando <= 1'b1;
        cnt     <= '0;
        emissor <= 1'b1;
      end else begin
        cnt     <= cnt_nxt;
        // Registered from the next count so emissor lines up with cnt.
        emissor <= (cnt_nxt < CNT_HALF);
        if (cnt == CNT_SMP_ON)  amostra_on  <= rx_s2;
        if (cnt == CNT_SMP_OFF) amostra_off <= rx_s2;
      end
    end
  end

  // Filter state register and evaluation outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado        <= LIVRE;
      fcnt          <= '0;
      periodo_fim   <= 1'b0;
      interferencia <= 1'b0;
    end else begin
      estado      <= estado_n;
      fcnt        <= fcnt_n;
      periodo_fim <= avaliar;
      if (avaliar) interferencia <= amostra_off;
    end
  end

  // Filter next state: counts consecutive periods that disagree with the
  // current state; any agreeing period restarts the count.
  always_comb begin
    estado_n = estado;
    fcnt_n   = fcnt;
    if (avaliar) begin
      case (estado)
        LIVRE: begin
          if (!feixe) begin
            if (fcnt == FC_CONFIRM) begin
              estado_n = BLOQUEADO;
              fcnt_n   = '0;
            end else begin
              fcnt_n = fcnt + FW'(1);
            end
          end else begin
            fcnt_n = '0;
          end
        end
        BLOQUEADO: begin
          if (feixe) begin
            if (fcnt == FC_RELEASE) begin
              estado_n = LIVRE;
              fcnt_n   = '0;
            end else begin
              fcnt_n = fcnt + FW'(1);
            end
          end else begin
            fcnt_n = '0;
          end
        end
        default: begin
          estado_n = LIVRE;
          fcnt_n   = '0;
        end
      endcase
    end
  end

  assign objeto_perto = (estado == BLOQUEADO);

endmodule

// File: tb/tb_barreira_detector.sv
// Directed bench for barreira_detector with HALF_PERIOD=10, SETTLE=4, N_CONFIRM=3, N_RELEASE=2.
// Each period is driven as echo (good), forced 0 (broken) or forced 1 (interference).
// Outputs are checked 1 time unit after every rising edge.
module tb_barreira_detector;

  localparam int HP = 10;
  localparam int PER = 2 * HP;

  localparam logic [1:0] K_ECHO = 2'd0;
  localparam logic [1:0] K_ZERO = 2'd1;
  localparam logic [1:0] K_ONE  = 2'd2;

  logic clk;
  logic rst_n;
  logic receptor;
  logic emissor;
  logic objeto_perto;
  logic interferencia;
  logic periodo_fim;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_em  = 1'b0;
  logic cur_obj  = 1'b0;
  logic cur_intf = 1'b0;

  barreira_detector #(
    .HALF_PERIOD(HP),
    .SETTLE     (4),
    .N_CONFIRM  (3),
    .N_RELEASE  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .receptor     (receptor),
    .emissor      (emissor),
    .objeto_perto (objeto_perto),
    .interferencia(interferencia),
    .periodo_fim  (periodo_fim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sets receptor for the coming cycle; echo is emissor delayed one cycle.
  task automatic drive(input logic [1:0] kind);
    case (kind)
      K_ECHO:  receptor = prev_em;
      K_ZERO:  receptor = 1'b0;
      default: receptor = 1'b1;
    endcase
    prev_em = emissor;
  endtask

  // Runs one full period of the given kind; counts 1..19 then 0 after the ticks.
  task automatic run_period(input logic [1:0] kind, input logic exp_obj,
                            input logic exp_intf, input string name);
    logic e_em, e_pf, e_obj, e_intf;
    for (int i = 1; i <= PER; i++) begin
      tick();
      e_em   = ((i % PER) < HP);
      e_pf   = (i == PER);
      e_obj  = (i == PER) ? exp_obj  : cur_obj;
      e_intf = (i == PER) ? exp_intf : cur_intf;
      n_checks += 4;
      if (emissor !== e_em) begin
        n_fail++;
        $display("FAIL %s emissor t%0d: got %b expected %b", name, i, emissor, e_em);
      end
      if (periodo_fim !== e_pf) begin
        n_fail++;
        $display("FAIL %s periodo_fim t%0d: got %b expected %b", name, i, periodo_fim, e_pf);
      end
      if (objeto_perto !== e_obj) begin
        n_fail++;
        $display("FAIL %s objeto_perto t%0d: got %b expected %b", name, i, objeto_perto, e_obj);
      end
      if (interferencia !== e_intf) begin
        n_fail++;
        $display("FAIL %s interferencia t%0d: got %b expected %b", name, i, interferencia, e_intf);
      end
      drive(kind);
    end
    cur_obj  = exp_obj;
    cur_intf = exp_intf;
  endtask

  // Releases reset and checks the first running edge (count 0, emitter on).
  task automatic start_run(input logic [1:0] first_kind, input string name);
    rst_n = 1'b1;
    tick();
    n_checks += 3;
    if (emissor !== 1'b1) begin
      n_fail++;
      $display("FAIL %s first edge emissor: got %b expected 1", name, emissor);
    end
    if (periodo_fim !== 1'b0) begin
      n_fail++;
      $display("FAIL %s first edge periodo_fim: got %b expected 0", name, periodo_fim);
    end
    if (objeto_perto !== 1'b0) begin
      n_fail++;
      $display("FAIL %s first edge objeto_perto: got %b expected 0", name, objeto_perto);
    end
    prev_em  = 1'b0;
    cur_obj  = 1'b0;
    cur_intf = 1'b0;
    drive(first_kind);
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks += 4;
    if (emissor !== 1'b0) begin
      n_fail++;
      $display("FAIL %s emissor: got %b expected 0", name, emissor);
    end
    if (objeto_perto !== 1'b0) begin
      n_fail++;
      $display("FAIL %s objeto_perto: got %b expected 0", name, objeto_perto);
    end
    if (interferencia !== 1'b0) begin
      n_fail++;
      $display("FAIL %s interferencia: got %b expected 0", name, interferencia);
    end
    if (periodo_fim !== 1'b0) begin
      n_fail++;
      $display("FAIL %s periodo_fim: got %b expected 0", name, periodo_fim);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    receptor = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs("reset");
    end
  endtask

  // Receptor low: emitter waveform and period pulses; two broken periods stay below N_CONFIRM.
  task automatic test_waveform();
    start_run(K_ZERO, "waveform");
    run_period(K_ZERO, 1'b0, 1'b0, "waveform_p1");
    run_period(K_ZERO, 1'b0, 1'b0, "waveform_p2");
  endtask

  task automatic test_echo();
    for (int p = 0; p < 10; p++) run_period(K_ECHO, 1'b0, 1'b0, "echo");
  endtask

  task automatic test_confirm_release();
    run_period(K_ZERO, 1'b0, 1'b0, "confirm_b1");
    run_period(K_ZERO, 1'b0, 1'b0, "confirm_b2");
    run_period(K_ZERO, 1'b1, 1'b0, "confirm_b3");
    run_period(K_ECHO, 1'b1, 1'b0, "release_g1");
    run_period(K_ECHO, 1'b0, 1'b0, "release_g2");
  endtask

  task automatic test_interference();
    run_period(K_ONE, 1'b0, 1'b1, "intf_p1");
    run_period(K_ONE, 1'b0, 1'b1, "intf_p2");
    run_period(K_ONE, 1'b1, 1'b1, "intf_p3");
    run_period(K_ECHO, 1'b1, 1'b0, "intf_clear_g1");
    run_period(K_ECHO, 1'b0, 1'b0, "intf_clear_g2");
  endtask

  task automatic test_hysteresis();
    for (int r = 0; r < 2; r++) begin
      run_period(K_ZERO, 1'b0, 1'b0, "hyst_livre_b1");
      run_period(K_ZERO, 1'b0, 1'b0, "hyst_livre_b2");
      run_period(K_ECHO, 1'b0, 1'b0, "hyst_livre_g");
    end
    run_period(K_ZERO, 1'b0, 1'b0, "hyst_lock_b1");
    run_period(K_ZERO, 1'b0, 1'b0, "hyst_lock_b2");
    run_period(K_ZERO, 1'b1, 1'b0, "hyst_lock_b3");
    for (int r = 0; r < 3; r++) begin
      run_period(K_ECHO, 1'b1, 1'b0, "hyst_bloq_g");
      run_period(K_ZERO, 1'b1, 1'b0, "hyst_bloq_b");
    end
  endtask

  // Reset pulse mid-period while blocked with interference flagged.
  task automatic test_reset_midrun();
    run_period(K_ONE, 1'b1, 1'b1, "midrun_intf");
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (periodo_fim !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_partial periodo_fim t%0d: got %b expected 0", i, periodo_fim);
      end
      drive(K_ZERO);
    end
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrun_reset");
    start_run(K_ZERO, "midrun_restart");
    run_period(K_ZERO, 1'b0, 1'b0, "midrun_b1");
    run_period(K_ZERO, 1'b0, 1'b0, "midrun_b2");
    run_period(K_ZERO, 1'b1, 1'b0, "midrun_b3");
  endtask

  initial begin
    rst_n    = 1'b0;
    receptor = 1'b0;
    test_reset();
    test_waveform();
    test_echo();
    test_confirm_release();
    test_interference();
    test_hysteresis();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/barreira_detector.md
Name: barreira_detector

Overview:
Upstream stage of the light-barrier chain. It drives the IR emitter with a square wave and samples the photoreceiver in both the ON and OFF phases. Each period is judged "beam present" or "beam broken", and the result is filtered with confirm/release counters. It produces the clean, registered `objeto_perto` level consumed by the LED controller. Modulation makes the barrier immune to steady ambient light and flags it as interference.

Parameters:
- HALF_PERIOD, 2500, clock cycles per emitter half-period (10 kHz at 50 MHz); must be ≥ 2.
- SETTLE, 500, cycles after each phase edge before sampling; 1 ≤ SETTLE < HALF_PERIOD.
- N_CONFIRM, 4, consecutive broken periods required to assert `objeto_perto`.
- N_RELEASE, 4, consecutive good periods required to deassert `objeto_perto`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- receptor  in  1  asynchronous photoreceiver output, 1 = light received
- emissor  out  1  IR emitter drive, 1 = LED on
- objeto_perto  out  1  filtered "object in barrier" level, to LED controller
- interferencia  out  1  ambient light seen in the OFF phase of the last period
- periodo_fim  out  1  one-cycle pulse marking each period evaluation

Behaviour:
- **Clocking and reset:** One clock, `clk`. Reset is synchronous and active-low on `rst_n`, sampled at the rising edge of `clk`.
  - On reset: phase counter = 0, sync flops = 0, samples = 0, filter counter = 0, state = LIVRE.
  - Output reset values: `emissor` = 0, `objeto_perto` = 0, `interferencia` = 0, `periodo_fim` = 0.
  - Reset asserted mid-operation (any state) has effect at the next edge; no pending evaluation survives.
- **Input synchronisation:** `receptor` passes through a 2-flop synchronizer. All sampling uses the synchronized value, so the effective input latency is 2 cycles.
- **Phase counter:**
  - Counts 0 .. 2*HALF_PERIOD-1 and wraps to 0.
  - The first edge with `rst_n` = 1 loads count 0 and starts running.
  - `emissor` is registered: it is 1 for counts 0 .. HALF_PERIOD-1 and 0 for counts HALF_PERIOD .. 2*HALF_PERIOD-1.
- **Sampling:**
  - `amostra_on` takes the synchronized receptor value at count == SETTLE.
  - `amostra_off` takes it at count == HALF_PERIOD+SETTLE.
- **Evaluation** happens at the edge where count == 2*HALF_PERIOD-1, with results visible the following cycle:
  - Period is good ("feixe") if `amostra_on` = 1 and `amostra_off` = 0; otherwise it is broken.
  - `interferencia` <= `amostra_off`, held until the next evaluation.
  - `periodo_fim` = 1 for exactly this one cycle.
  - Interference counts as broken (fail-safe).
- **Filter FSM (2 states), filter counter width = clog2(max(N_CONFIRM, N_RELEASE)+1):**
  - LIVRE (`objeto_perto` = 0):
    - Broken period: counter+1. When it reaches N_CONFIRM, go to BLOQUEADO, clear the counter, and set `objeto_perto` = 1 in the same cycle as `periodo_fim`.
    - Good period: counter = 0.
  - BLOQUEADO (`objeto_perto` = 1):
    - Good period: counter+1. When it reaches N_RELEASE, go to LIVRE, clear the counter, and set `objeto_perto` = 0.
    - Broken period: counter = 0.
  - The counter never exceeds its target and never wraps.
- **Update timing:** `objeto_perto` and `interferencia` change only in the cycle where `periodo_fim` = 1.
- **Receptor edges near sample points:** Edges on `receptor` between sample points have no effect. Edges near sample points resolve only via the synchronizer; there is no metastability propagation.
- **Worst-case detection latency:** N_CONFIRM*2*HALF_PERIOD + 2*HALF_PERIOD cycles.

Test Plan (HALF_PERIOD = 10, SETTLE = 4, N_CONFIRM = 3, N_RELEASE = 2):
1. Release reset, `receptor` = 0 → `emissor` is high 10 cycles / low 10 cycles repeating. `periodo_fim` pulses every 20 cycles, the first one 20 cycles after the first running edge.
2. `receptor` = `emissor` delayed 1 cycle, run 10 periods → `objeto_perto` = 0 and `interferencia` = 0 throughout.
3. Good echo, then `receptor` forced 0 → `objeto_perto` rises in the `periodo_fim` cycle of the 3rd broken period. Restore echo → it falls at the 2nd good period's `periodo_fim`.
4. `receptor` held 1 constantly → `interferencia` = 1 from the first `periodo_fim`; `objeto_perto` = 1 from the 3rd.
5. Pattern of 2 broken, 1 good, 2 broken, 1 good → `objeto_perto` never asserts. Symmetric case in BLOQUEADO (1 good, 1 broken, repeated) → it never releases.
6. Pull `rst_n` low for 1 cycle while BLOQUEADO → next edge `objeto_perto` = 0, `emissor` = 0, `interferencia` = 0. The period restarts from count 0, and 3 fresh broken periods are needed to re-assert.
